multicycle_rv32_core: RTL
=========================

Name: multicycle_rv32_core

Overview:
Parametrised successor to the team's addi/sw multicycle core.
- Implements the full RV32I base integer subset, minus FENCE/ECALL/EBREAK/CSR, as a 5-state multicycle FSM over a single shared memory port.
- Adds a request/ready handshake so memory may insert wait states, plus byte write strobes.
- Sits between the testbench/SoC memory model and nothing else; it is the sole bus master.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NREGS, 32, number of architectural registers (32 = RV32I, 16 = RV32E); register indices >= NREGS are treated as illegal instructions.

Ports:
- clk  input  1  clock, rising edge.
- resetn  input  1  asynchronous, active-low reset.
- address  output  32  memory byte address, always word-aligned (bits [1:0] = 0).
- data_out  output  32  store data, lane-aligned to address bits of the access.
- data_in  input  32  read data; sampled only when req && ready.
- we  output  1  1 = write transfer, 0 = read.
- wstrb  output  4  byte-lane write enables; 4'b0000 on reads.
- req  output  1  transfer request; address/we/wstrb/data_out stable while req=1.
- ready  input  1  memory completes the transfer in the cycle req && ready.
- retire  output  1  one-cycle pulse when an instruction completes (legal or illegal).
- illegal  output  1  one-cycle pulse, coincident with retire, for unsupported/illegal/misaligned instructions.

Behaviour:
- Reset (async, resetn=0):
  - pc=RESET_PC; state=FETCH.
  - All registers zeroed.
  - address=0, data_out=0, we=0, wstrb=0, req=0, retire=0, illegal=0.
- Reset asserted mid-transfer aborts immediately; no partial register write survives.
- States: FETCH, DECODE, EXECUTE, MEM, WB.
- FETCH:
  - req=1, we=0, address=pc.
  - Stay in FETCH while ready=0.
  - On ready=1, latch data_in into ir and go to DECODE.
- DECODE:
  - Decode ir; read rs1/rs2; build immediate (I/S/B/U/J, sign-extended).
  - Go to EXECUTE.
  - Unsupported opcode, or register index >= NREGS: pc+=4, pulse retire+illegal, go to FETCH.
- EXECUTE (ALU):
  - Integer ops: ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND and their immediate forms; shifts use bits [4:0] only.
  - LUI/AUIPC/JAL/JALR go to WB.
  - JALR target = (rs1+imm) & ~1.
  - Branch (BEQ/BNE/BLT/BGE/BLTU/BGEU): pc = taken ? pc+imm : pc+4; pulse retire; go to FETCH.
  - Load/store: effective address = rs1+imm. If misaligned (half with ea[0]=1, word with ea[1:0]!=0): pc+=4, pulse retire+illegal, no bus access, go to FETCH. Otherwise go to MEM.
- MEM:
  - req=1, address={ea[31:2],2'b00}.
  - Store: we=1; wstrb = 4'b0001<<ea[1:0] for SB, 4'b0011<<ea[1:0] for SH, 4'b1111 for SW; data_out = rs2 replicated into lanes.
  - Hold until ready=1.
  - Store completes: pc+=4, retire, go to FETCH.
  - Load completes: extract lane from data_in, sign- or zero-extend (LB/LH/LW/LBU/LHU), go to WB.
- WB:
  - Write rd unless rd=0 (x0 always reads 0).
  - pc = next-pc (pc+4, or jump target for JAL/JALR; link value = old pc+4).
  - Pulse retire; go to FETCH.
- Zero-wait latency:
  - branch 3 cycles.
  - ALU/LUI/AUIPC/JAL/JALR 4 cycles.
  - store 4 cycles.
  - load 5 cycles.
  - Each cycle with ready=0 in FETCH/MEM adds one.
- req drops to 0 in DECODE/EXECUTE/WB. we/wstrb are 0 whenever req=0.
- PC arithmetic wraps modulo 2^32 (0xFFFF_FFFC+4 = 0).
- Misaligned jump targets are not checked: the fetch address is forced word-aligned.

Optional Feature:
- Macro: MULTICYCLE_CORE_MUL_EN.
- Defined: OP with funct7=7'b0000001, funct3=000 (MUL) writes low 32 bits of rs1*rs2 via EXECUTE→WB, 4-cycle latency.
- Not defined: any funct7=0000001 encoding is illegal (pc+=4, retire+illegal pulse).

Decomposition:
- Package core_pkg holds:
  - opcode constants (LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP_IMM, OP);
  - funct3 constants;
  - state enum (FETCH..WB);
  - ALU operation enum.
- Sub-module core_alu: combinational; inputs a, b, alu_op; outputs result and the branch-compare flags eq/lt/ltu.

Test Plan:
- ADDI x1,x0,5; ADDI x2,x1,-3, ready tied 1 → x2=2; two retire pulses 4 cycles apart; x0 write attempt (ADDI x0,x0,7) leaves x0=0.
- x1=0x100, x2=0x8765_4321; SB x2,1(x1) → one write, address=0x100, wstrb=4'b0010, data_out[15:8]=0x21; then LB x3,1(x1) with memory returning 0x0000_8100 → x3=0xFFFF_FF81; LBU gives 0x81.
- ready low for 3 cycles during FETCH and MEM → req/address held constant; load total latency 5+6=11 cycles; retire exactly once.
- BNE x1,x2,-8 with x1≠x2 at pc=0x20 → next fetch address 0x18; with x1=x2 → 0x24; JAL x5,16 at 0x40 → x5=0x44, next fetch 0x50.
- LW at ea=0x102, or opcode 7'b1111111 → no bus write, illegal+retire pulse, pc advances by 4.
- resetn pulled low mid-MEM store, async → req/we drop the same cycle without a clock edge; after release, first fetch at RESET_PC and all registers read 0.

Source files
------------

// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared opcodes, funct3 codes, FSM states and ALU ops for multicycle_rv32_core
package core_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [2:0] F3_LB   = 3'b000;
    localparam logic [2:0] F3_LH   = 3'b001;
    localparam logic [2:0] F3_LW   = 3'b010;
    localparam logic [2:0] F3_LBU  = 3'b100;
    localparam logic [2:0] F3_LHU  = 3'b101;

    typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, MEM, WB} state_t;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_MUL
    } alu_op_t;

    function automatic logic [31:0] imm_of(input logic [31:0] ir);
        case (ir[6:0])
            OPC_LUI, OPC_AUIPC: imm_of = {ir[31:12], 12'b0};
            OPC_JAL:            imm_of = {{12{ir[31]}}, ir[19:12], ir[20], ir[30:21], 1'b0};
            OPC_BRANCH:         imm_of = {{20{ir[31]}}, ir[7], ir[30:25], ir[11:8], 1'b0};
            OPC_STORE:          imm_of = {{21{ir[31]}}, ir[30:25], ir[11:7]};
            default:            imm_of = {{21{ir[31]}}, ir[30:20]};
        endcase
    endfunction

    // alt is instr bit 30; it only selects SUB for register-register ops, never for ADDI
    function automatic alu_op_t alu_op_of(input logic [2:0] f3, input logic alt, input logic is_op);
        case (f3)
            F3_ADD:  alu_op_of = (alt && is_op) ? ALU_SUB : ALU_ADD;
            F3_SLL:  alu_op_of = ALU_SLL;
            F3_SLT:  alu_op_of = ALU_SLT;
            F3_SLTU: alu_op_of = ALU_SLTU;
            F3_XOR:  alu_op_of = ALU_XOR;
            F3_SR:   alu_op_of = alt ? ALU_SRA : ALU_SRL;
            F3_OR:   alu_op_of = ALU_OR;
            default: alu_op_of = ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/core_alu.sv
// rtl/core_alu.sv - combinational ALU with branch compare flags; multiply only with MULTICYCLE_CORE_MUL_EN
module core_alu
    import core_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  alu_op_t     alu_op,
    output logic [31:0] result,
    output logic        eq,
    output logic        lt,
    output logic        ltu
);

    always_comb begin
        eq  = (a == b);
        lt  = ($signed(a) < $signed(b));
        ltu = (a < b);
        case (alu_op)
            ALU_SUB:  result = a - b;
            ALU_SLL:  result = a << b[4:0];
            ALU_SLT:  result = {31'b0, lt};
            ALU_SLTU: result = {31'b0, ltu};
            ALU_XOR:  result = a ^ b;
            ALU_SRL:  result = a >> b[4:0];
            ALU_SRA:  result = 32'($signed(a) >>> b[4:0]);
            ALU_OR:   result = a | b;
            ALU_AND:  result = a & b;
`ifdef MULTICYCLE_CORE_MUL_EN
            ALU_MUL:  result = a * b;
`endif
            default:  result = a + b;
        endcase
    end

endmodule

// File: rtl/multicycle_rv32_core.sv
// rtl/multicycle_rv32_core.sv - RV32I/E multicycle core, single memory port; MUL via MULTICYCLE_CORE_MUL_EN
module multicycle_rv32_core
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          NREGS    = 32
) (
    input  logic        clk,
    input  logic        resetn,
    output logic [31:0] address,
    output logic [31:0] data_out,
    input  logic [31:0] data_in,
    output logic        we,
    output logic [3:0]  wstrb,
    output logic        req,
    input  logic        ready,
    output logic        retire,
    output logic        illegal
);

    localparam int RW = $clog2(NREGS);

    state_t      state;
    logic [31:0] pc, ir, rs1_q, rs2_q, imm_q, wb_data_q, next_pc_q;
    logic [1:0]  ea_lo;
    logic [31:0] rf [NREGS];

    logic [6:0]  opcode, f7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    assign opcode = ir[6:0];
    assign rd     = ir[11:7];
    assign f3     = ir[14:12];
    assign rs1    = ir[19:15];
    assign rs2    = ir[24:20];
    assign f7     = ir[31:25];

    function automatic logic reg_ok(input logic [4:0] r);
        return 32'(r) < NREGS;
    endfunction

    logic legal_op, use_rd, use_rs1, use_rs2, dec_legal;

    always_comb begin
        legal_op = 1'b0;
        use_rd   = 1'b0;
        use_rs1  = 1'b0;
        use_rs2  = 1'b0;
        case (opcode)
            OPC_LUI, OPC_AUIPC, OPC_JAL: begin
                legal_op = 1'b1;
                use_rd   = 1'b1;
            end
            OPC_JALR: begin
                legal_op = (f3 == 3'b000);
                use_rd   = 1'b1;
                use_rs1  = 1'b1;
            end
            OPC_BRANCH: begin
                legal_op = (f3 != 3'b010) && (f3 != 3'b011);
                use_rs1  = 1'b1;
                use_rs2  = 1'b1;
            end
            OPC_LOAD: begin
                legal_op = (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
                           (f3 == F3_LBU) || (f3 == F3_LHU);
                use_rd   = 1'b1;
                use_rs1  = 1'b1;
            end
            OPC_STORE: begin
                legal_op = (f3[2] == 1'b0) && (f3[1:0] != 2'b11);
                use_rs1  = 1'b1;
                use_rs2  = 1'b1;
            end
            OPC_OP_IMM: begin
                if (f3 == F3_SLL)
                    legal_op = (f7 == 7'b0000000);
                else if (f3 == F3_SR)
                    legal_op = (f7 == 7'b0000000) || (f7 == 7'b0100000);
                else
                    legal_op = 1'b1;
                use_rd   = 1'b1;
                use_rs1  = 1'b1;
            end
            OPC_OP: begin
                legal_op = (f7 == 7'b0000000) ||
                           ((f7 == 7'b0100000) && ((f3 == F3_ADD) || (f3 == F3_SR)))
`ifdef MULTICYCLE_CORE_MUL_EN
                           || ((f7 == 7'b0000001) && (f3 == F3_ADD))
`endif
                           ;
                use_rd   = 1'b1;
                use_rs1  = 1'b1;
                use_rs2  = 1'b1;
            end
            default: legal_op = 1'b0;
        endcase
        dec_legal = legal_op && (!use_rd || reg_ok(rd)) &&
                    (!use_rs1 || reg_ok(rs1)) && (!use_rs2 || reg_ok(rs2));
    end

    alu_op_t     alu_op;
    logic [31:0] alu_a, alu_b, alu_result;
    logic        alu_eq, alu_lt, alu_ltu;

    always_comb begin
        alu_op = ALU_ADD;
        alu_a  = rs1_q;
        alu_b  = imm_q;
        case (opcode)
            OPC_LUI:   alu_a = 32'd0;
            OPC_AUIPC: alu_a = pc;
            OPC_JAL, OPC_JALR: begin
                alu_a = pc;
                alu_b = 32'd4;
            end
            OPC_BRANCH: alu_b = rs2_q;
            OPC_OP_IMM: alu_op = alu_op_of(f3, ir[30], 1'b0);
            OPC_OP: begin
                alu_b  = rs2_q;
                alu_op = (f7 == 7'b0000001) ? ALU_MUL : alu_op_of(f3, ir[30], 1'b1);
            end
            default: ;
        endcase
    end

    core_alu u_alu (
        .a      (alu_a),
        .b      (alu_b),
        .alu_op (alu_op),
        .result (alu_result),
        .eq     (alu_eq),
        .lt     (alu_lt),
        .ltu    (alu_ltu)
    );

    logic [31:0] pc_plus4, br_target, jalr_target, st_data, ld_lane, ld_data;
    logic [3:0]  st_strb;
    logic        taken, misaligned;

    assign pc_plus4    = pc + 32'd4;
    assign br_target   = pc + imm_q;
    assign jalr_target = (rs1_q + imm_q) & ~32'd1;
    assign misaligned  = ((f3[1:0] == 2'b01) && alu_result[0]) ||
                         ((f3[1:0] == 2'b10) && (alu_result[1:0] != 2'b00));
    assign ld_lane     = data_in >> {ea_lo, 3'b000};

    always_comb begin
        case (f3)
            F3_BEQ:  taken = alu_eq;
            F3_BNE:  taken = !alu_eq;
            F3_BLT:  taken = alu_lt;
            F3_BGE:  taken = !alu_lt;
            F3_BLTU: taken = alu_ltu;
            F3_BGEU: taken = !alu_ltu;
            default: taken = 1'b0;
        endcase
        case (f3[1:0])
            2'b00: begin
                st_data = {4{rs2_q[7:0]}};
                st_strb = 4'b0001 << alu_result[1:0];
            end
            2'b01: begin
                st_data = {2{rs2_q[15:0]}};
                st_strb = 4'b0011 << alu_result[1:0];
            end
            default: begin
                st_data = rs2_q;
                st_strb = 4'b1111;
            end
        endcase
        case (f3)
            F3_LB:   ld_data = {{24{ld_lane[7]}}, ld_lane[7:0]};
            F3_LH:   ld_data = {{16{ld_lane[15]}}, ld_lane[15:0]};
            F3_LBU:  ld_data = {24'b0, ld_lane[7:0]};
            F3_LHU:  ld_data = {16'b0, ld_lane[15:0]};
            default: ld_data = data_in;
        endcase
    end

    // Every path back to FETCH raises req and loads the aligned fetch address in the same edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= FETCH;
            pc        <= RESET_PC;
            ir        <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            imm_q     <= '0;
            wb_data_q <= '0;
            next_pc_q <= '0;
            ea_lo     <= '0;
            address   <= '0;
            data_out  <= '0;
            we        <= 1'b0;
            wstrb     <= 4'b0000;
            req       <= 1'b0;
            retire    <= 1'b0;
            illegal   <= 1'b0;
            for (int i = 0; i < NREGS; i++)
                rf[i] <= '0;
        end else begin
            retire  <= 1'b0;
            illegal <= 1'b0;
            case (state)
                FETCH: begin
                    if (!req) begin
                        req     <= 1'b1;
                        address <= {pc[31:2], 2'b00};
                    end else if (ready) begin
                        ir    <= data_in;
                        req   <= 1'b0;
                        state <= DECODE;
                    end
                end
                DECODE: begin
                    rs1_q <= rf[rs1[RW-1:0]];
                    rs2_q <= rf[rs2[RW-1:0]];
                    imm_q <= imm_of(ir);
                    if (!dec_legal) begin
                        pc      <= pc_plus4;
                        retire  <= 1'b1;
                        illegal <= 1'b1;
                        req     <= 1'b1;
                        address <= {pc_plus4[31:2], 2'b00};
                        state   <= FETCH;
                    end else begin
                        state <= EXECUTE;
                    end
                end
                EXECUTE: begin
                    wb_data_q <= alu_result;
                    ea_lo     <= alu_result[1:0];
                    if (opcode == OPC_BRANCH) begin
                        pc      <= taken ? br_target : pc_plus4;
                        address <= taken ? {br_target[31:2], 2'b00} : {pc_plus4[31:2], 2'b00};
                        req     <= 1'b1;
                        retire  <= 1'b1;
                        state   <= FETCH;
                    end else if ((opcode == OPC_LOAD) || (opcode == OPC_STORE)) begin
                        next_pc_q <= pc_plus4;
                        if (misaligned) begin
                            pc      <= pc_plus4;
                            retire  <= 1'b1;
                            illegal <= 1'b1;
                            address <= {pc_plus4[31:2], 2'b00};
                            state   <= FETCH;
                        end else begin
                            address  <= {alu_result[31:2], 2'b00};
                            we       <= (opcode == OPC_STORE);
                            wstrb    <= (opcode == OPC_STORE) ? st_strb : 4'b0000;
                            data_out <= (opcode == OPC_STORE) ? st_data : 32'd0;
                            state    <= MEM;
                        end
                        req <= 1'b1;
                    end else begin
                        next_pc_q <= (opcode == OPC_JAL)  ? br_target :
                                     (opcode == OPC_JALR) ? jalr_target : pc_plus4;
                        state     <= WB;
                    end
                end
                MEM: begin
                    if (ready) begin
                        we       <= 1'b0;
                        wstrb    <= 4'b0000;
                        data_out <= '0;
                        if (opcode == OPC_STORE) begin
                            pc      <= pc_plus4;
                            address <= {pc_plus4[31:2], 2'b00};
                            retire  <= 1'b1;
                            state   <= FETCH;
                        end else begin
                            wb_data_q <= ld_data;
                            req       <= 1'b0;
                            state     <= WB;
                        end
                    end
                end
                WB: begin
                    if (rd != 5'd0)
                        rf[rd[RW-1:0]] <= wb_data_q;
                    pc      <= next_pc_q;
                    address <= {next_pc_q[31:2], 2'b00};
                    req     <= 1'b1;
                    retire  <= 1'b1;
                    state   <= FETCH;
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule
